// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline-stage buffers: default widths, the NOP
// instruction and the bubble control encoding.
package pipe_pkg;

  localparam int INSTR_W_DEF = 16;
  localparam int DATA_W_DEF  = 48;
  localparam int CTRL_W_DEF  = 12;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF = 16'h0800;

  // Every control bit is write-type, so a bubble's control word is all zeros.
  localparam logic BUBBLE_CTRL_BIT = 1'b0;

  function automatic logic [1:0] countValid(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Upstream/downstream valid-ready bus of one pipeline stage; the stage itself
// takes the slave side, the producer/consumer environment the master side.
interface pipe_stage_buf_if #(
  parameter int INSTR_W = pipe_pkg::INSTR_W_DEF,
  parameter int DATA_W  = pipe_pkg::DATA_W_DEF,
  parameter int CTRL_W  = pipe_pkg::CTRL_W_DEF
);

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [DATA_W-1:0]  in_data;
  logic [CTRL_W-1:0]  in_ctrl;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [DATA_W-1:0]  out_data;
  logic [CTRL_W-1:0]  out_ctrl;
  logic [1:0]         occupancy;

  modport master (
    output in_valid, in_instr, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_instr, out_data, out_ctrl, occupancy
  );

  modport slave (
    input  in_valid, in_instr, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_instr, out_data, out_ctrl, occupancy
  );

endinterface

// File: rtl/pipe_entry_reg.sv
// One buffered pipeline entry: a valid flag plus the packed {instr, data, ctrl}
// word. Clear wins over load.
module pipe_entry_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] dIn,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= dIn;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and NOP-bubble output masking.
module pipe_stage_buf #(
  parameter int                 DATA_W    = pipe_pkg::DATA_W_DEF,
  parameter int                 CTRL_W    = pipe_pkg::CTRL_W_DEF,
  parameter int                 INSTR_W   = pipe_pkg::INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(pipe_pkg::NOP_INSTR_DEF),
  parameter bit                 SKID_EN   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  pipe_stage_buf_if.slave bus
);

  import pipe_pkg::*;

  localparam int WORD_W = INSTR_W + DATA_W + CTRL_W;

  logic [WORD_W-1:0] inWord;
  logic [WORD_W-1:0] mDin;
  logic [WORD_W-1:0] mQ;
  logic              mValid;
  logic              mLoad;
  logic              mClear;
  logic              sValid;
  logic              inReady;
  logic              inFire;
  logic              outFire;

  assign inWord  = {bus.in_instr, bus.in_data, bus.in_ctrl};
  assign inFire  = bus.in_valid & inReady;
  assign outFire = mValid & bus.out_ready;

  pipe_entry_reg #(.W(WORD_W)) mEntry (
    .clk   (clk),
    .rst   (rst),
    .load  (mLoad),
    .clear (mClear),
    .dIn   (mDin),
    .valid (mValid),
    .q     (mQ)
  );

  generate
    if (SKID_EN) begin : gSkid
      logic [WORD_W-1:0] sQ;
      logic              sLoad;
      logic              sClear;

      // in_ready comes straight off the skid valid flop, so out_ready never
      // reaches upstream combinationally; the skid entry absorbs that slack.
      assign inReady = ~sValid;
      assign sLoad   = ~flush & inFire & mValid & ~outFire;
      assign sClear  = flush | (outFire & sValid);
      assign mLoad   = ~flush & ((outFire & sValid) | (inFire & (~mValid | outFire)));
      assign mClear  = flush | (outFire & ~sValid & ~inFire);
      assign mDin    = sValid ? sQ : inWord;

      pipe_entry_reg #(.W(WORD_W)) sEntry (
        .clk   (clk),
        .rst   (rst),
        .load  (sLoad),
        .clear (sClear),
        .dIn   (inWord),
        .valid (sValid),
        .q     (sQ)
      );
    end else begin : gSingle
      assign sValid  = 1'b0;
      assign inReady = ~mValid | bus.out_ready;
      assign mLoad   = ~flush & inFire;
      assign mClear  = flush | (outFire & ~inFire);
      assign mDin    = inWord;
    end
  endgenerate

  // An empty stage presents a bubble regardless of what the entry still holds.
  assign bus.in_ready  = inReady;
  assign bus.out_valid = mValid;
  assign bus.out_instr = mValid ? mQ[WORD_W-1 -: INSTR_W] : NOP_INSTR;
  assign bus.out_data  = mValid ? mQ[CTRL_W +: DATA_W] : '0;
  assign bus.out_ctrl  = mValid ? mQ[CTRL_W-1:0] : {CTRL_W{BUBBLE_CTRL_BIT}};
  assign bus.occupancy = countValid(mValid, sValid);

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench: drives a skid-buffered and a single-entry stage with
// the same stimulus and compares each against a queue-based reference model.
module tb_pipe_stage_buf;

  localparam int IW = 16;
  localparam int DW = 48;
  localparam int CW = 12;
  localparam int WW = IW + DW + CW;

  typedef logic [WW-1:0] wordQ_t [$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  int compared = 0;
  int mismatched = 0;
  wordQ_t held [2];

  always #5 clk = ~clk;

  pipe_stage_buf_if #(.INSTR_W(IW), .DATA_W(DW), .CTRL_W(CW)) bus1 ();
  pipe_stage_buf_if #(.INSTR_W(IW), .DATA_W(DW), .CTRL_W(CW)) bus0 ();

  pipe_stage_buf #(
    .DATA_W(DW), .CTRL_W(CW), .INSTR_W(IW), .NOP_INSTR(16'h0800), .SKID_EN(1'b1)
  ) dut1 (.clk(clk), .rst(rst), .flush(flush), .bus(bus1));

  pipe_stage_buf #(
    .DATA_W(DW), .CTRL_W(CW), .INSTR_W(IW), .NOP_INSTR(16'h0800), .SKID_EN(1'b0)
  ) dut0 (.clk(clk), .rst(rst), .flush(flush), .bus(bus0));

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [DW-1:0] rdata();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  function automatic logic [CW-1:0] rctrl();
    logic [31:0] t;
    t = $urandom();
    return t[CW-1:0];
  endfunction

  function automatic logic [IW-1:0] rinstr();
    logic [31:0] t;
    t = $urandom();
    return t[IW-1:0];
  endfunction

  // Reference: a stage is an ordered list of held entries. Capacity 2 with
  // ready = not full (skid), or capacity 1 with ready = empty or downstream
  // ready (single). Flush empties the list; the head is consumed regardless.
  function automatic void checkStage(
    input int k, input logic skid, input logic inRdy, input logic oValid,
    input logic [IW-1:0] oInstr, input logic [DW-1:0] oData, input logic [CW-1:0] oCtrl,
    input logic [1:0] occ, input logic inValid, input logic [WW-1:0] inWord,
    input logic oReady, input logic fl);
    int n;
    logic expReady;
    logic inFire;
    logic outFire;
    logic [WW-1:0] head;
    string tag;
    n = held[k].size();
    tag = skid ? "skid" : "single";
    expReady = skid ? (n < 2) : (n == 0 || oReady);
    head = (n > 0) ? held[k][0] : {16'h0800, 48'h0, 12'h0};
    chk({tag, " in_ready"}, 128'(inRdy), 128'(expReady));
    chk({tag, " out_valid"}, 128'(oValid), 128'(n > 0));
    chk({tag, " occupancy"}, 128'(occ), 128'(n));
    chk({tag, " out_instr"}, 128'(oInstr), 128'(head[WW-1 -: IW]));
    chk({tag, " out_data"}, 128'(oData), 128'(head[CW +: DW]));
    chk({tag, " out_ctrl"}, 128'(oCtrl), 128'(head[CW-1:0]));
    inFire = inValid && expReady;
    outFire = (n > 0) && oReady;
    if (outFire)
      $display("[%s] t=%0t out instr=%h data=%h ctrl=%h", tag, $time, oInstr, oData, oCtrl);
    if (fl) begin
      held[k].delete();
    end else begin
      if (outFire) void'(held[k].pop_front());
      if (inFire) held[k].push_back(inWord);
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      checkStage(1, 1'b1, bus1.in_ready, bus1.out_valid, bus1.out_instr, bus1.out_data,
                 bus1.out_ctrl, bus1.occupancy, bus1.in_valid,
                 {bus1.in_instr, bus1.in_data, bus1.in_ctrl}, bus1.out_ready, flush);
      checkStage(0, 1'b0, bus0.in_ready, bus0.out_valid, bus0.out_instr, bus0.out_data,
                 bus0.out_ctrl, bus0.occupancy, bus0.in_valid,
                 {bus0.in_instr, bus0.in_data, bus0.in_ctrl}, bus0.out_ready, flush);
    end
  end

  task automatic drive(input logic v, input logic [IW-1:0] i, input logic [DW-1:0] d,
                       input logic [CW-1:0] c, input logic ordy, input logic fl);
    bus1.in_valid = v;    bus0.in_valid = v;
    bus1.in_instr = i;    bus0.in_instr = i;
    bus1.in_data = d;     bus0.in_data = d;
    bus1.in_ctrl = c;     bus0.in_ctrl = c;
    bus1.out_ready = ordy; bus0.out_ready = ordy;
    flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy, input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b0, '0, '0, '0, ordy, 1'b0);
  endtask

  task automatic checkResetOutputs(input string when);
    chk({when, " skid out_valid"}, 128'(bus1.out_valid), 128'(0));
    chk({when, " skid out_instr"}, 128'(bus1.out_instr), 128'(16'h0800));
    chk({when, " skid out_data"}, 128'(bus1.out_data), 128'(0));
    chk({when, " skid out_ctrl"}, 128'(bus1.out_ctrl), 128'(0));
    chk({when, " skid occupancy"}, 128'(bus1.occupancy), 128'(0));
    chk({when, " single out_valid"}, 128'(bus0.out_valid), 128'(0));
    chk({when, " single out_instr"}, 128'(bus0.out_instr), 128'(16'h0800));
    chk({when, " single occupancy"}, 128'(bus0.occupancy), 128'(0));
  endtask

  initial begin
    logic [IW-1:0] ins;
    bus1.in_valid = 1'b0; bus0.in_valid = 1'b0;
    bus1.in_instr = '0;   bus0.in_instr = '0;
    bus1.in_data = '0;    bus0.in_data = '0;
    bus1.in_ctrl = '0;    bus0.in_ctrl = '0;
    bus1.out_ready = 1'b0; bus0.out_ready = 1'b0;
    #1;
    checkResetOutputs("reset");
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("reset skid in_ready", 128'(bus1.in_ready), 128'(1));
    chk("reset single in_ready", 128'(bus0.in_ready), 128'(1));
    @(posedge clk);
    #1;

    // Streaming at full rate
    for (int i = 0; i < 8; i++) begin
      ins = 16'h1000 + 16'(i);
      drive(1'b1, ins, rdata(), rctrl(), 1'b1, 1'b0);
    end
    idle(1'b1, 3);

    // Backpressure into the skid entry, then release
    drive(1'b1, 16'h2A00, rdata(), rctrl(), 1'b0, 1'b0);
    drive(1'b1, 16'h2B00, rdata(), rctrl(), 1'b0, 1'b0);
    idle(1'b0, 2);
    idle(1'b1, 3);

    // Flush a full buffer while C is offered
    drive(1'b1, 16'h3A00, rdata(), rctrl(), 1'b0, 1'b0);
    drive(1'b1, 16'h3B00, rdata(), rctrl(), 1'b0, 1'b0);
    drive(1'b1, 16'h3C00, rdata(), rctrl(), 1'b0, 1'b1);
    idle(1'b1, 2);

    // Flush with simultaneous in_fire and out_fire
    drive(1'b1, 16'h3D00, rdata(), rctrl(), 1'b0, 1'b0);
    drive(1'b1, 16'h3C01, rdata(), rctrl(), 1'b1, 1'b1);
    idle(1'b1, 2);

    // Single-entry stall, then sustained throughput on release
    drive(1'b1, 16'h4A00, rdata(), rctrl(), 1'b0, 1'b0);
    drive(1'b1, 16'h4B00, rdata(), rctrl(), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ins = 16'h4C00 + 16'(i);
      drive(1'b1, ins, rdata(), rctrl(), 1'b1, 1'b0);
    end
    idle(1'b1, 3);

    // Bubble masking with all-ones inputs held invalid
    for (int i = 0; i < 3; i++)
      drive(1'b0, 16'hFFFF, 48'hFFFF_FFFF_FFFF, 12'hFFF, 1'b1, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, rinstr(), rdata(), rctrl(),
            $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
    end
    idle(1'b1, 3);

    // Asynchronous reset in the middle of a clock period with both entries full
    drive(1'b1, 16'h5A00, rdata(), rctrl(), 1'b0, 1'b0);
    drive(1'b1, 16'h5B00, rdata(), rctrl(), 1'b0, 1'b0);
    bus1.in_valid = 1'b0; bus0.in_valid = 1'b0;
    chk("pre-reset skid occupancy", 128'(bus1.occupancy), 128'(2));
    #1 rst = 1'b0;
    held[0].delete();
    held[1].delete();
    #1;
    checkResetOutputs("mid-reset");
    #1 rst = 1'b1;
    #1;
    chk("post-reset skid in_ready", 128'(bus1.in_ready), 128'(1));
    chk("post-reset single in_ready", 128'(bus0.in_ready), 128'(1));
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++)
      drive($urandom_range(0, 1) == 1, rinstr(), rdata(), rctrl(), $urandom_range(0, 1) == 1, 1'b0);
    idle(1'b1, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline-stage register for the next-generation 5-stage datapath; replaces the fixed-width, enable-only stage latches.
- Carries one instruction word, a generic payload bus and a control-bit bus between stages.
- Uses a valid/ready handshake with an optional 2-entry skid buffer, so stalls need no global combinational enable path.
- Supports a synchronous flush and drives a NOP bubble whenever the stage is empty.

Parameters:
- DATA_W, 48: payload width in bits (e.g. PCInc, ALUOut, ReadData2 concatenated).
- CTRL_W, 12: control-bit width; all bits are treated as write-type and are masked to 0 in a bubble.
- INSTR_W, 16: instruction word width.
- NOP_INSTR, 16'h0800: instruction value driven when the stage holds no valid entry.
- SKID_EN, 1: 1 selects the 2-entry skid buffer with registered in_ready; 0 selects a single entry with combinational in_ready.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: reset; asynchronous, active-low.
- flush, input, 1: synchronous discard of all held entries.
- in_valid, input, 1: upstream entry valid.
- in_ready, output, 1: stage can accept an entry this cycle.
- in_instr, input, INSTR_W: upstream instruction.
- in_data, input, DATA_W: upstream payload.
- in_ctrl, input, CTRL_W: upstream control bits.
- out_valid, output, 1: head entry valid.
- out_ready, input, 1: downstream accepts the head entry.
- out_instr, output, INSTR_W: head instruction, or NOP_INSTR when out_valid=0.
- out_data, output, DATA_W: head payload, or 0 when out_valid=0.
- out_ctrl, output, CTRL_W: head control bits, or 0 when out_valid=0.
- occupancy, output, 2: number of held entries (0..2; max 1 when SKID_EN=0).

Behaviour:
- Transfer definitions:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- Reset (rst=0, asynchronous):
  - Both entries become invalid.
  - All storage registers clear to 0.
  - Outputs settle to out_valid=0, out_instr=NOP_INSTR, out_data=0, out_ctrl=0, occupancy=0, and in_ready=1.
  - Reset asserted mid-stream drops all entries immediately, without waiting for a clock edge.
- Storage: main entry M (drives the outputs) and skid entry S (SKID_EN=1 only). out_valid = M.valid.
- Bubble masking: when M.valid=0, out_instr, out_data and out_ctrl are forced to their bubble values combinationally, regardless of stored contents.
- SKID_EN=1 rules, evaluated per edge with flush=0:
  - in_ready = ~S.valid, driven from a register with no combinational path from out_ready.
  - M empty, in_fire: input loads M.
  - M full, out_fire, in_fire, S empty: input loads M.
  - M full, no out_fire, in_fire: input loads S.
  - out_fire, S full: S moves to M and S is cleared. in_fire cannot occur because in_ready=0.
  - out_fire, no in_fire, S empty: M is cleared.
- SKID_EN=0 rules:
  - in_ready = ~M.valid | out_ready.
  - in_fire loads M.
  - out_fire without in_fire clears M.
- Latency and throughput:
  - One cycle from in_fire to out_valid.
  - Full throughput of 1 entry/cycle when out_ready is held high.
  - Entries leave in order, with no loss and no duplication.
- Flush:
  - Takes priority over every transfer.
  - At the next edge M.valid=0 and S.valid=0.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still counts as consumed downstream.
  - in_ready is not gated by flush.
- occupancy = M.valid + S.valid. An invariant holds: S.valid implies M.valid.
- Widths: no arithmetic on payload. occupancy is a 2-bit unsigned value.

Decomposition:
- Shared package pipe_pkg holds:
  - the NOP_INSTR constant (16'h0800);
  - the default stage widths;
  - a localparam for the encoding of the bubble control word (all zeros).
- One sub-module, pipe_entry_reg: a valid bit plus a {instr, data, ctrl} register with load and clear inputs and asynchronous active-low reset.
  - Instantiated once for M.
  - Instantiated once for S when SKID_EN=1, using a generate block.

Test Plan:
- Reset mid-stream: with M and S both full, pulse rst low between edges. Outputs go immediately to out_valid=0, out_instr=16'h0800, out_ctrl=0, occupancy=0, and in_ready=1 after release.
- Streaming: out_ready=1, 8 back-to-back entries with in_instr=16'h1000..16'h1007. Each appears one cycle after acceptance, in order, with in_ready held at 1.
- Backpressure/skid (SKID_EN=1):
  - Drop out_ready with A in M and send B. B goes to S, occupancy=2, in_ready=0 next cycle.
  - Raise out_ready. A then B emerge on consecutive cycles.
- Flush with a full buffer and a simultaneous in_fire of C: the next cycle shows occupancy=0 and out_instr=16'h0800, and C never appears.
- SKID_EN=0 stall: with M full and out_ready=0, in_ready=0 in the same cycle. Setting out_ready=1 gives in_ready=1 combinationally and sustains 1 entry/cycle.
- Bubble masking: with in_valid=0 for 3 cycles while in_ctrl is all ones and in_data=48'hFFFF_FFFF_FFFF, outputs stay out_ctrl=0, out_data=0, out_instr=16'h0800.
